// File: rtl/regs_mp_sb_pkg.sv
// Shared defaults and helpers for the multi-port register file.
// Defines the core width/depth macros used as parameter defaults.
`ifndef REG_LENGTH_32I
`define REG_LENGTH_32I 32
`endif
`ifndef REG_DEPTH_32I
`define REG_DEPTH_32I 32
`endif
`ifndef RF_NRD_DEFAULT
`define RF_NRD_DEFAULT 2
`endif
`ifndef RF_NWR_DEFAULT
`define RF_NWR_DEFAULT 1
`endif

package regs_mp_sb_pkg;

    localparam int RF_XLEN_DEFAULT  = `REG_LENGTH_32I;
    localparam int RF_NREGS_DEFAULT = `REG_DEPTH_32I;
    localparam int RF_NRD_DEFAULT   = `RF_NRD_DEFAULT;
    localparam int RF_NWR_DEFAULT   = `RF_NWR_DEFAULT;

    // True when a read/write of this address targets the hardwired zero.
    function automatic logic is_zero_hit(input int zero_reg,
                                         input logic [31:0] addr);
        return (zero_reg != 0) && (addr == 32'd0);
    endfunction

endpackage

// File: rtl/regs_mp_scoreboard.sv
// Per-register busy scoreboard: set on alloc, clear on write, flush all.
// Ports: clk/reset, wr_en_i/wr_addr_i, alloc_en_i/alloc_addr_i, flush_i,
//        rd_addr_i + byp_hit_i (per read port) -> rd_busy_o.
module regs_mp_scoreboard
    import regs_mp_sb_pkg::*;
#(
    parameter int NREGS    = RF_NREGS_DEFAULT,
    parameter int NRD      = RF_NRD_DEFAULT,
    parameter int NWR      = RF_NWR_DEFAULT,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NWR-1:0]    wr_en_i,
    input  logic [NWR*AW-1:0] wr_addr_i,
    input  logic              alloc_en_i,
    input  logic [AW-1:0]     alloc_addr_i,
    input  logic              flush_i,
    input  logic [NRD*AW-1:0] rd_addr_i,
    input  logic [NRD-1:0]    byp_hit_i,
    output logic [NRD-1:0]    rd_busy_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Clear, then set, then flush: a same-cycle alloc survives the
    // write it races with because the new producer is still pending.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en_i[j]) begin
                busy_d[wr_addr_i[j*AW +: AW]] = 1'b0;
            end
        end
        if (alloc_en_i &&
            !is_zero_hit(ZERO_REG, 32'(alloc_addr_i))) begin
            busy_d[alloc_addr_i] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A writeback on the read address resolves the hazard this cycle.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        assign rd_busy_o[k] = busy_q[rd_addr_i[k*AW +: AW]]
                              & ~byp_hit_i[k];
    end

endmodule

// File: rtl/regs_mp_sb.sv
// Multi-port integer register file with write-to-read bypass,
// optional hardwired zero register and a busy scoreboard.
// Ports: clk, reset (sync, active-high); rd_addr -> rd_data/rd_busy;
//        wr_en/wr_addr/wr_data; alloc_en/alloc_addr; flush.
module regs_mp_sb
    import regs_mp_sb_pkg::*;
#(
    parameter int XLEN     = `REG_LENGTH_32I,
    parameter int NREGS    = `REG_DEPTH_32I,
    parameter int NRD      = `RF_NRD_DEFAULT,
    parameter int NWR      = `RF_NWR_DEFAULT,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    input  logic                flush
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [NRD-1:0]  byp_hit;

    // Ascending port order lets the highest-index writer win.
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] &&
                !is_zero_hit(ZERO_REG, 32'(wr_addr[j*AW +: AW]))) begin
                regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            hit;

        assign addr = rd_addr[k*AW +: AW];

        always_comb begin
            data = regs_q[addr];
            hit  = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] == addr)) begin
                    data = wr_data[j*XLEN +: XLEN];
                    hit  = 1'b1;
                end
            end
            // Zero register wins over any bypass; it is never busy.
            if (is_zero_hit(ZERO_REG, 32'(addr))) begin
                data = '0;
                hit  = 1'b0;
            end
        end

        assign rd_data[k*XLEN +: XLEN] = data;
        assign byp_hit[k]              = hit;
    end

    regs_mp_scoreboard #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_sb (
        .clk          (clk),
        .reset        (reset),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .alloc_en_i   (alloc_en),
        .alloc_addr_i (alloc_addr),
        .flush_i      (flush),
        .rd_addr_i    (rd_addr),
        .byp_hit_i    (byp_hit),
        .rd_busy_o    (rd_busy)
    );

endmodule

// File: tb/tb_regs_mp_sb.sv
// Bench for regs_mp_sb: directed checks on a 32x32 2R2W zero-reg file
// and a model-checked random run on a 64x64 4R2W file without zero reg.
module tb_regs_mp_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---- DUT A: XLEN 32, NREGS 32, NRD 2, NWR 2, ZERO_REG 1
    logic        a_reset;
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic [1:0]  a_wr_en;
    logic [9:0]  a_wr_addr;
    logic [63:0] a_wr_data;
    logic        a_alloc_en;
    logic [4:0]  a_alloc_addr;
    logic        a_flush;

    regs_mp_sb #(
        .XLEN (32), .NREGS (32), .NRD (2), .NWR (2), .ZERO_REG (1)
    ) dut_a (
        .clk        (clk),
        .reset      (a_reset),
        .rd_addr    (a_rd_addr),
        .rd_data    (a_rd_data),
        .rd_busy    (a_rd_busy),
        .wr_en      (a_wr_en),
        .wr_addr    (a_wr_addr),
        .wr_data    (a_wr_data),
        .alloc_en   (a_alloc_en),
        .alloc_addr (a_alloc_addr),
        .flush      (a_flush)
    );

    // ---- DUT B: XLEN 64, NREGS 64, NRD 4, NWR 2, ZERO_REG 0
    logic         b_reset;
    logic [23:0]  b_rd_addr;
    logic [255:0] b_rd_data;
    logic [3:0]   b_rd_busy;
    logic [1:0]   b_wr_en;
    logic [11:0]  b_wr_addr;
    logic [127:0] b_wr_data;
    logic         b_alloc_en;
    logic [5:0]   b_alloc_addr;
    logic         b_flush;

    regs_mp_sb #(
        .XLEN (64), .NREGS (64), .NRD (4), .NWR (2), .ZERO_REG (0)
    ) dut_b (
        .clk        (clk),
        .reset      (b_reset),
        .rd_addr    (b_rd_addr),
        .rd_data    (b_rd_data),
        .rd_busy    (b_rd_busy),
        .wr_en      (b_wr_en),
        .wr_addr    (b_wr_addr),
        .wr_data    (b_wr_data),
        .alloc_en   (b_alloc_en),
        .alloc_addr (b_alloc_addr),
        .flush      (b_flush)
    );

    task automatic a_idle();
        a_wr_en    = '0;
        a_wr_addr  = '0;
        a_wr_data  = '0;
        a_alloc_en = 1'b0;
        a_alloc_addr = '0;
        a_flush    = 1'b0;
    endtask

    task automatic a_wr(input int p, input logic [4:0] ad,
                        input logic [31:0] d);
        a_wr_en[p]            = 1'b1;
        a_wr_addr[p*5 +: 5]   = ad;
        a_wr_data[p*32 +: 32] = d;
    endtask

    function automatic logic [5:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) begin
            return 6'($urandom_range(0, 63));
        end
        return 6'($urandom_range(0, 7));
    endfunction

    logic [63:0] m_mem [64];
    logic [63:0] m_bsy;

    initial begin
        a_idle();
        a_reset   = 1'b1;
        a_rd_addr = '0;
        b_reset   = 1'b1;
        b_rd_addr = '0;
        b_wr_en   = '0;
        b_wr_addr = '0;
        b_wr_data = '0;
        b_alloc_en = 1'b0;
        b_alloc_addr = '0;
        b_flush   = 1'b0;
        tick();
        tick();
        a_reset = 1'b0;
        b_reset = 1'b0;

        // reset state
        a_rd_addr = {5'd5, 5'd7};
        #1;
        check("rst_rd0", 64'(a_rd_data[31:0]), 64'h0);
        check("rst_rd1", 64'(a_rd_data[63:32]), 64'h0);
        check("rst_busy", 64'(a_rd_busy), 64'h0);

        // test 1: write+alloc r5, then reset clears data and busy
        a_wr(0, 5'd5, 32'hDEADBEEF);
        a_alloc_en = 1'b1;
        a_alloc_addr = 5'd5;
        tick();
        a_idle();
        a_rd_addr = {5'd0, 5'd5};
        #1;
        check("t1_pre_data", 64'(a_rd_data[31:0]), 64'hDEADBEEF);
        check("t1_pre_busy", 64'(a_rd_busy[0]), 64'h1);
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        #1;
        check("t1_data", 64'(a_rd_data[31:0]), 64'h0);
        check("t1_busy", 64'(a_rd_busy), 64'h0);

        // test 2: same-cycle bypass, then value from the array
        a_wr(0, 5'd7, 32'h1234);
        a_rd_addr = {5'd0, 5'd7};
        #1;
        check("t2_byp", 64'(a_rd_data[31:0]), 64'h1234);
        tick();
        a_idle();
        #1;
        check("t2_arr", 64'(a_rd_data[31:0]), 64'h1234);

        // test 3: zero register ignores writes and allocs
        a_wr(1, 5'd0, 32'hFFFFFFFF);
        a_alloc_en = 1'b1;
        a_alloc_addr = 5'd0;
        a_rd_addr = {5'd0, 5'd0};
        #1;
        check("t3_byp", 64'(a_rd_data[31:0]), 64'h0);
        check("t3_byp_busy", 64'(a_rd_busy), 64'h0);
        tick();
        a_idle();
        #1;
        check("t3_arr", 64'(a_rd_data[63:32]), 64'h0);
        check("t3_busy", 64'(a_rd_busy), 64'h0);

        // test 4: two ports write r3, port 1 wins
        a_wr(0, 5'd3, 32'hA);
        a_wr(1, 5'd3, 32'hB);
        a_rd_addr = {5'd7, 5'd3};
        #1;
        check("t4_byp", 64'(a_rd_data[31:0]), 64'hB);
        check("t4_other", 64'(a_rd_data[63:32]), 64'h1234);
        tick();
        a_idle();
        #1;
        check("t4_arr", 64'(a_rd_data[31:0]), 64'hB);

        // test 5: scoreboard
        a_alloc_en = 1'b1;
        a_alloc_addr = 5'd9;
        a_rd_addr = {5'd9, 5'd3};
        #1;
        check("t5_alloc_same", 64'(a_rd_busy[1]), 64'h0);
        tick();
        a_idle();
        #1;
        check("t5_alloc_next", 64'(a_rd_busy[1]), 64'h1);
        a_wr(0, 5'd9, 32'h55);
        #1;
        check("t5_wb_busy", 64'(a_rd_busy[1]), 64'h0);
        check("t5_wb_data", 64'(a_rd_data[63:32]), 64'h55);
        tick();
        a_idle();
        #1;
        check("t5_cleared", 64'(a_rd_busy[1]), 64'h0);
        a_alloc_en = 1'b1;
        a_alloc_addr = 5'd9;
        a_wr(1, 5'd9, 32'h66);
        tick();
        a_idle();
        #1;
        check("t5_alloc_wr", 64'(a_rd_busy[1]), 64'h1);
        check("t5_alloc_wr_d", 64'(a_rd_data[63:32]), 64'h66);
        a_alloc_en = 1'b1;
        a_alloc_addr = 5'd10;
        tick();
        a_idle();
        a_rd_addr = {5'd9, 5'd10};
        #1;
        check("t5_two_busy", 64'(a_rd_busy), 64'h3);
        a_flush = 1'b1;
        a_alloc_en = 1'b1;
        a_alloc_addr = 5'd11;
        tick();
        a_idle();
        #1;
        check("t5_flush", 64'(a_rd_busy), 64'h0);
        a_rd_addr = {5'd11, 5'd10};
        #1;
        check("t5_flush_alloc", 64'(a_rd_busy), 64'h0);

        // test 6: random traffic against a reference model
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
        m_bsy = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            b_reset = ($urandom_range(0, 59) == 0);
            b_flush = ($urandom_range(0, 19) == 0);
            b_alloc_en = ($urandom_range(0, 2) == 0);
            b_alloc_addr = rnd_addr();
            for (int j = 0; j < 2; j++) begin
                b_wr_en[j] = ($urandom_range(0, 1) == 1);
                b_wr_addr[j*6 +: 6] = rnd_addr();
                b_wr_data[j*64 +: 64] = {$urandom, $urandom};
            end
            for (int k = 0; k < 4; k++) begin
                b_rd_addr[k*6 +: 6] = rnd_addr();
            end
            #1;
            for (int k = 0; k < 4; k++) begin
                logic [5:0]  ra;
                logic [63:0] ed;
                logic        hit;
                ra  = b_rd_addr[k*6 +: 6];
                ed  = m_mem[ra];
                hit = 1'b0;
                for (int j = 0; j < 2; j++) begin
                    if (b_wr_en[j] && b_wr_addr[j*6 +: 6] == ra) begin
                        ed  = b_wr_data[j*64 +: 64];
                        hit = 1'b1;
                    end
                end
                check($sformatf("t6_data c%0d p%0d", cyc, k),
                      b_rd_data[k*64 +: 64], ed);
                check($sformatf("t6_busy c%0d p%0d", cyc, k),
                      64'(b_rd_busy[k]), 64'(m_bsy[ra] & ~hit));
            end
            if (b_reset) begin
                for (int i = 0; i < 64; i++) m_mem[i] = '0;
                m_bsy = '0;
            end else begin
                for (int j = 0; j < 2; j++) begin
                    if (b_wr_en[j]) begin
                        m_mem[b_wr_addr[j*6 +: 6]] = b_wr_data[j*64 +: 64];
                        m_bsy[b_wr_addr[j*6 +: 6]] = 1'b0;
                    end
                end
                if (b_alloc_en) m_bsy[b_alloc_addr] = 1'b1;
                if (b_flush) m_bsy = '0;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
